// File: rtl/axi_sram_responder_if.sv
// rtl/axi_sram_responder_if.sv - AXI4-Lite bus bundle between the memory-side master and the SRAM responder
interface axi_sram_responder_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [7:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_sram_responder.sv
// rtl/axi_sram_responder.sv - AXI4-Lite word SRAM responder with programmable latency; AXI_SRAM_RAND_DELAY_EN selects LFSR latencies
module axi_sram_responder #(
  parameter logic [31:0] BASE       = 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 10,
  parameter int          READ_LAT   = 2,
  parameter int          WRITE_LAT  = 2
) (
  input logic                 clk,
  input logic                 rst,
  axi_sram_responder_if.slave s
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        aw_got_q, aw_got_d;
  logic        w_got_q, w_got_d;
  logic [31:0] rd_addr_q, rd_addr_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [3:0]  wr_strb_q, wr_strb_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        rvalid_q, rvalid_d;
  logic        bvalid_q, bvalid_d;
  logic        mem_we;
  logic        txn_acc;
  logic [3:0]  rd_lat, wr_lat;

  // Word storage; contents survive reset.
  logic [31:0] mem_q [DEPTH];

  // Decode works on the latched addresses so the response reflects the accepted request.
  logic [31:0]           rd_off, wr_off;
  logic                  rd_in, wr_in;
  logic [DEPTH_LOG2-1:0] rd_idx, wr_idx;

  assign rd_off = rd_addr_q - BASE;
  assign wr_off = wr_addr_q - BASE;
  assign rd_in  = (rd_addr_q >= BASE) && (rd_off[31:DEPTH_LOG2+2] == '0);
  assign wr_in  = (wr_addr_q >= BASE) && (wr_off[31:DEPTH_LOG2+2] == '0);
  assign rd_idx = rd_off[DEPTH_LOG2+1:2];
  assign wr_idx = wr_off[DEPTH_LOG2+1:2];

  // A pending read blocks new write captures; a half-captured write blocks reads.
  assign s.arready = (state_q == IDLE) && !aw_got_q && !w_got_q;
  assign s.awready = (state_q == IDLE) && !aw_got_q && !s.arvalid;
  assign s.wready  = (state_q == IDLE) && !w_got_q && !s.arvalid;
  assign s.rdata   = rdata_q;
  assign s.rresp   = rresp_q;
  assign s.rvalid  = rvalid_q;
  assign s.bresp   = bresp_q;
  assign s.bvalid  = bvalid_q;

`ifdef AXI_SRAM_RAND_DELAY_EN
  logic [3:0] lfsr_q, lfsr_d;

  assign rd_lat = lfsr_q;
  assign wr_lat = lfsr_q;

  // Step the x^4+x^3+1 sequence once per accepted read or completed write capture.
  always_comb begin
    lfsr_d = lfsr_q;
    if (txn_acc) lfsr_d = {lfsr_q[0] ^ lfsr_q[1], lfsr_q[3:1]};
  end

  // LFSR register, seeded to a non-zero value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= 4'b1001;
    else      lfsr_q <= lfsr_d;
  end
`else
  assign rd_lat = 4'(READ_LAT);
  assign wr_lat = 4'(WRITE_LAT);
`endif

  logic unused_bits;
  assign unused_bits = ^{rd_off[1:0], wr_off[1:0], s.wstrb[7:4], txn_acc};

  // Next-state logic: capture, countdown, response generation and handshake.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_strb_d = wr_strb_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rvalid_d  = rvalid_q;
    bresp_d   = bresp_q;
    bvalid_d  = bvalid_q;
    mem_we    = 1'b0;
    txn_acc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (s.arvalid && s.arready) begin
          rd_addr_d = s.araddr;
          cnt_d     = rd_lat;
          txn_acc   = 1'b1;
          state_d   = RD_WAIT;
        end else begin
          if (s.awvalid && s.awready) begin
            aw_got_d  = 1'b1;
            wr_addr_d = s.awaddr;
          end
          if (s.wvalid && s.wready) begin
            w_got_d   = 1'b1;
            wr_data_d = s.wdata;
            wr_strb_d = s.wstrb[3:0];
          end
          if (aw_got_d && w_got_d) begin
            cnt_d   = wr_lat;
            txn_acc = 1'b1;
            state_d = WR_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == 4'd0) begin
          rdata_d  = rd_in ? mem_q[rd_idx] : 32'h0;
          rresp_d  = rd_in ? 2'b00 : 2'b10;
          rvalid_d = 1'b1;
          state_d  = RD_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RD_RESP: begin
        if (s.rready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      WR_WAIT: begin
        if (cnt_q == 4'd0) begin
          mem_we   = wr_in;
          bresp_d  = wr_in ? 2'b00 : 2'b10;
          bvalid_d = 1'b1;
          state_d  = WR_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WR_RESP: begin
        if (s.bready) begin
          bvalid_d = 1'b0;
          aw_got_d = 1'b0;
          w_got_d  = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and response registers; reset drops valids and abandons any pending write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rvalid_q  <= 1'b0;
      bresp_q   <= '0;
      bvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_strb_q <= wr_strb_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rvalid_q  <= rvalid_d;
      bresp_q   <= bresp_d;
      bvalid_q  <= bvalid_d;
    end
  end

  // Byte-merged commit on the WR_WAIT to WR_RESP edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_strb_q[i]) mem_q[wr_idx][8*i +: 8] <= wr_data_q[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axi_sram_responder.sv
// tb/tb_axi_sram_responder.sv - scoreboard bench for axi_sram_responder
module tb_axi_sram_responder;
  localparam logic [31:0] BASE      = 32'h8000_0000;
  localparam int          READ_LAT  = 2;
  localparam int          WRITE_LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_sram_responder_if bus();

  axi_sram_responder #(
    .BASE(BASE), .DEPTH_LOG2(10), .READ_LAT(READ_LAT), .WRITE_LAT(WRITE_LAT)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .s(bus)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  strb;
    int          aw_delay;
  } op_t;

  typedef struct packed {
    logic [7:0]  lat;
    logic [1:0]  resp;
    logic [31:0] data;
  } obs_t;

  int vectors = 0;
  int errors  = 0;
  obs_t exp_q[$];
  logic [31:0] model [int];

`ifdef AXI_SRAM_RAND_DELAY_EN
  logic [3:0] tb_lfsr = 4'b1001;
  function automatic int next_lat(input bit wr);
    int l;
    l = int'(tb_lfsr);
    tb_lfsr = {tb_lfsr[0] ^ tb_lfsr[1], tb_lfsr[3:1]};
    return l + 1;
  endfunction
  function automatic void lfsr_reset_model();
    tb_lfsr = 4'b1001;
  endfunction
`else
  function automatic int next_lat(input bit wr);
    return (wr ? WRITE_LAT : READ_LAT) + 1;
  endfunction
  function automatic void lfsr_reset_model();
  endfunction
`endif

  function automatic op_t mk(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                             input logic [7:0] strb, input int dly);
    op_t o;
    o.wr = wr; o.addr = addr; o.data = data; o.strb = strb; o.aw_delay = dly;
    return o;
  endfunction

  // Reference model: range check, byte merge, expected latency.
  function automatic obs_t expect_op(input op_t op);
    obs_t e;
    logic [31:0] w;
    bit inr;
    int idx;
    inr = (op.addr >= BASE) && ((op.addr - BASE) < 32'h1000);
    idx = int'((op.addr - BASE) >> 2);
    e.lat = 8'(next_lat(op.wr));
    e.resp = inr ? 2'b00 : 2'b10;
    if (op.wr) begin
      e.data = 32'h0;
      if (inr) begin
        w = model.exists(idx) ? model[idx] : 32'hxxxx_xxxx;
        for (int b = 0; b < 4; b++) if (op.strb[b]) w[8*b +: 8] = op.data[8*b +: 8];
        model[idx] = w;
      end
    end else begin
      e.data = inr ? model[idx] : 32'h0;
    end
    return e;
  endfunction

  task automatic run_op(input op_t op, output obs_t o);
    int n;
    bit aw_done, w_done, aw_fire, w_fire, ar_fire;
    o = '0;
    if (op.wr) begin
      bus.awaddr = op.addr; bus.wdata = op.data; bus.wstrb = op.strb;
      bus.wvalid = 1'b1; bus.awvalid = (op.aw_delay == 0);
      aw_done = 0; w_done = 0; n = 0;
      while (!(aw_done && w_done) && n < 50) begin
        aw_fire = bus.awvalid && bus.awready;
        w_fire  = bus.wvalid && bus.wready;
        @(posedge clk); #1; n++;
        if (aw_fire) begin aw_done = 1; bus.awvalid = 1'b0; end
        if (w_fire) begin w_done = 1; bus.wvalid = 1'b0; end
        if (!aw_done && n >= op.aw_delay) bus.awvalid = 1'b1;
      end
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      n = 0;
      while (!bus.bvalid && n < 40) begin @(posedge clk); #1; n++; end
      o.lat = bus.bvalid ? 8'(n) : 8'hFF;
      o.resp = bus.bresp;
      bus.bready = 1'b1; @(posedge clk); #1; bus.bready = 1'b0;
    end else begin
      bus.araddr = op.addr; bus.arvalid = 1'b1; n = 0;
      while (n < 50) begin
        ar_fire = bus.arready;
        @(posedge clk); #1; n++;
        if (ar_fire) break;
      end
      bus.arvalid = 1'b0;
      n = 0;
      while (!bus.rvalid && n < 40) begin @(posedge clk); #1; n++; end
      o.lat = bus.rvalid ? 8'(n) : 8'hFF;
      o.resp = bus.rresp; o.data = bus.rdata;
      bus.rready = 1'b1; @(posedge clk); #1; bus.rready = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({bus.rvalid, bus.bvalid, bus.rresp, bus.bresp, bus.rdata} !== 38'h0) begin
      errors++;
      $display("FAIL reset_outputs: got rv=%b bv=%b rresp=%b bresp=%b rdata=%h, want all zero",
               bus.rvalid, bus.bvalid, bus.rresp, bus.bresp, bus.rdata);
    end
    vectors++;
    if ({bus.arready, bus.awready, bus.wready} !== 3'b111) begin
      errors++;
      $display("FAIL reset_ready: got %b want 111", {bus.arready, bus.awready, bus.wready});
    end
    @(posedge clk); #2; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    op_t ops[$];
    obs_t e, g;
    ops.push_back(mk(1, BASE + 32'h10, 32'hDEAD_BEEF, 8'h0F, 0));
    ops.push_back(mk(0, BASE + 32'h10, 32'h0, 8'h00, 0));
    foreach (ops[i]) begin
      exp_q.push_back(expect_op(ops[i]));
      run_op(ops[i], g);
      e = exp_q.pop_front();
      vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL write_read[%0d]: got lat=%0d resp=%b data=%h, want lat=%0d resp=%b data=%h",
                 i, g.lat, g.resp, g.data, e.lat, e.resp, e.data);
      end
    end
  endtask

  task automatic test_byte_strobe();
    op_t ops[$];
    obs_t e, g;
    ops.push_back(mk(1, BASE + 32'h10, 32'h0000_AA00, 8'h02, 0));
    ops.push_back(mk(0, BASE + 32'h10, 32'h0, 8'h00, 0));
    ops.push_back(mk(1, BASE + 32'h10, 32'hFFFF_FFFF, 8'hF0, 0));
    ops.push_back(mk(0, BASE + 32'h10, 32'h0, 8'h00, 0));
    foreach (ops[i]) begin
      exp_q.push_back(expect_op(ops[i]));
      run_op(ops[i], g);
      e = exp_q.pop_front();
      vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL byte_strobe[%0d]: got lat=%0d resp=%b data=%h, want lat=%0d resp=%b data=%h",
                 i, g.lat, g.resp, g.data, e.lat, e.resp, e.data);
      end
      if (!ops[i].wr) begin
        vectors++;
        if (g.data !== 32'hDEAD_AAEF) begin
          errors++;
          $display("FAIL byte_strobe_value[%0d]: got %h want deadaaef", i, g.data);
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    op_t ops[$];
    obs_t e, g;
    ops.push_back(mk(1, BASE, 32'h1234_5678, 8'h0F, 0));
    ops.push_back(mk(0, 32'h9000_0000, 32'h0, 8'h00, 0));
    ops.push_back(mk(0, BASE - 32'h4, 32'h0, 8'h00, 0));
    ops.push_back(mk(1, BASE + 32'h1000, 32'hFFFF_FFFF, 8'h0F, 0));
    ops.push_back(mk(0, BASE, 32'h0, 8'h00, 0));
    ops.push_back(mk(1, BASE + 32'hFFC, 32'hCAFE_F00D, 8'h0F, 0));
    ops.push_back(mk(0, BASE + 32'hFFC, 32'h0, 8'h00, 0));
    ops.push_back(mk(1, BASE + 32'hFFC, 32'h5555_5555, 8'h00, 0));
    ops.push_back(mk(0, BASE + 32'hFFE, 32'h0, 8'h00, 0));
    foreach (ops[i]) begin
      exp_q.push_back(expect_op(ops[i]));
      run_op(ops[i], g);
      e = exp_q.pop_front();
      vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL out_of_range[%0d]: got lat=%0d resp=%b data=%h, want lat=%0d resp=%b data=%h",
                 i, g.lat, g.resp, g.data, e.lat, e.resp, e.data);
      end
    end
  endtask

  task automatic test_w_before_aw();
    op_t ops[$];
    obs_t e, g;
    ops.push_back(mk(1, BASE + 32'h30, 32'hA5A5_5A5A, 8'h0F, 4));
    ops.push_back(mk(0, BASE + 32'h30, 32'h0, 8'h00, 0));
    foreach (ops[i]) begin
      exp_q.push_back(expect_op(ops[i]));
      run_op(ops[i], g);
      e = exp_q.pop_front();
      vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL w_before_aw[%0d]: got lat=%0d resp=%b data=%h, want lat=%0d resp=%b data=%h",
                 i, g.lat, g.resp, g.data, e.lat, e.resp, e.data);
      end
    end
  endtask

  task automatic test_contention();
    obs_t e;
    int n;
    exp_q.push_back(expect_op(mk(0, BASE + 32'h10, 32'h0, 8'h00, 0)));
    exp_q.push_back(expect_op(mk(1, BASE + 32'h20, 32'h0BAD_C0DE, 8'h0F, 0)));
    bus.araddr = BASE + 32'h10; bus.arvalid = 1'b1;
    bus.awaddr = BASE + 32'h20; bus.awvalid = 1'b1;
    bus.wdata = 32'h0BAD_C0DE; bus.wstrb = 8'h0F; bus.wvalid = 1'b1;
    #1;
    vectors++;
    if ({bus.arready, bus.awready, bus.wready} !== 3'b100) begin
      errors++;
      $display("FAIL contention_ready: got %b want 100", {bus.arready, bus.awready, bus.wready});
    end
    @(posedge clk); #1; bus.arvalid = 1'b0;
    n = 0;
    while (!bus.rvalid && n < 40) begin @(posedge clk); #1; n++; end
    e = exp_q.pop_front();
    vectors++;
    if ({(bus.rvalid ? 8'(n) : 8'hFF), bus.rresp, bus.rdata} !== e) begin
      errors++;
      $display("FAIL contention_read: got lat=%0d resp=%b data=%h, want lat=%0d resp=%b data=%h",
               n, bus.rresp, bus.rdata, e.lat, e.resp, e.data);
    end
    bus.rready = 1'b1; @(posedge clk); #1; bus.rready = 1'b0;
    vectors++;
    if ({bus.awready, bus.wready} !== 2'b11) begin
      errors++;
      $display("FAIL contention_aw_after_r: got %b want 11", {bus.awready, bus.wready});
    end
    @(posedge clk); #1; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 40) begin @(posedge clk); #1; n++; end
    e = exp_q.pop_front();
    vectors++;
    if ({(bus.bvalid ? 8'(n) : 8'hFF), bus.bresp, 32'h0} !== e) begin
      errors++;
      $display("FAIL contention_write: got lat=%0d resp=%b, want lat=%0d resp=%b", n, bus.bresp, e.lat, e.resp);
    end
    bus.bready = 1'b1; @(posedge clk); #1; bus.bready = 1'b0;
  endtask

  task automatic test_backpressure();
    obs_t e;
    int n;
    exp_q.push_back(expect_op(mk(0, BASE + 32'h20, 32'h0, 8'h00, 0)));
    bus.araddr = BASE + 32'h20; bus.arvalid = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!bus.rvalid && n < 40) begin @(posedge clk); #1; n++; end
    e = exp_q.pop_front();
    vectors++;
    if ({(bus.rvalid ? 8'(n) : 8'hFF), bus.rresp, bus.rdata} !== e) begin
      errors++;
      $display("FAIL bp_first: got lat=%0d resp=%b data=%h, want lat=%0d resp=%b data=%h",
               n, bus.rresp, bus.rdata, e.lat, e.resp, e.data);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      vectors++;
      if ({bus.rvalid, bus.arready, bus.rresp, bus.rdata} !== {2'b10, e.resp, e.data}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got rv=%b arready=%b resp=%b data=%h, want rv=1 arready=0 resp=%b data=%h",
                 k, bus.rvalid, bus.arready, bus.rresp, bus.rdata, e.resp, e.data);
      end
    end
    bus.rready = 1'b1; @(posedge clk); #1; bus.rready = 1'b0;
    vectors++;
    if ({bus.rvalid, bus.arready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_after_handshake: got rv=%b arready=%b want rv=0 arready=1", bus.rvalid, bus.arready);
    end
    exp_q.push_back(expect_op(mk(0, BASE + 32'h20, 32'h0, 8'h00, 0)));
    @(posedge clk); #1; bus.arvalid = 1'b0;
    n = 0;
    while (!bus.rvalid && n < 40) begin @(posedge clk); #1; n++; end
    e = exp_q.pop_front();
    vectors++;
    if ({(bus.rvalid ? 8'(n) : 8'hFF), bus.rresp, bus.rdata} !== e) begin
      errors++;
      $display("FAIL bp_second: got lat=%0d resp=%b data=%h, want lat=%0d resp=%b data=%h",
               n, bus.rresp, bus.rdata, e.lat, e.resp, e.data);
    end
    bus.rready = 1'b1; @(posedge clk); #1; bus.rready = 1'b0;
  endtask

  task automatic test_reset_mid();
    op_t o;
    obs_t e, g;
    int n;
    o = mk(1, BASE + 32'h40, 32'h1111_2222, 8'h0F, 0);
    e = expect_op(o);
    run_op(o, g);
    vectors++;
    if (g !== e) begin
      errors++;
      $display("FAIL rst_prep_write: got lat=%0d resp=%b, want lat=%0d resp=%b", g.lat, g.resp, e.lat, e.resp);
    end
    bus.araddr = BASE + 32'h40; bus.arvalid = 1'b1;
    @(posedge clk); #1; bus.arvalid = 1'b0;
    void'(next_lat(1'b0));
    n = 0;
    while (!bus.rvalid && n < 40) begin @(posedge clk); #1; n++; end
    #2; rst_n = 1'b0; #1;
    lfsr_reset_model();
    vectors++;
    if ({bus.rvalid, bus.arready} !== 2'b01) begin
      errors++;
      $display("FAIL rst_rvalid_drop: got rv=%b arready=%b want rv=0 arready=1", bus.rvalid, bus.arready);
    end
    @(posedge clk); #2; rst_n = 1'b1;
    @(posedge clk); #1;
    bus.awaddr = BASE + 32'h40; bus.awvalid = 1'b1;
    bus.wdata = 32'h3333_4444; bus.wstrb = 8'h0F; bus.wvalid = 1'b1;
    @(posedge clk); #1; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    void'(next_lat(1'b1));
    @(posedge clk); #2; rst_n = 1'b0; #1;
    lfsr_reset_model();
    vectors++;
    if ({bus.bvalid, bus.arready, bus.awready, bus.wready} !== 4'b0111) begin
      errors++;
      $display("FAIL rst_wr_wait: got bv=%b ready=%b want bv=0 ready=111",
               bus.bvalid, {bus.arready, bus.awready, bus.wready});
    end
    repeat (4) @(posedge clk);
    #2; rst_n = 1'b1;
    @(posedge clk); #1;
    o = mk(0, BASE + 32'h40, 32'h0, 8'h00, 0);
    e = expect_op(o);
    run_op(o, g);
    vectors++;
    if (g !== e) begin
      errors++;
      $display("FAIL rst_write_discarded: got lat=%0d resp=%b data=%h, want lat=%0d resp=%b data=%h",
               g.lat, g.resp, g.data, e.lat, e.resp, e.data);
    end
  endtask

  initial begin
    bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.awaddr = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_write_read();
    test_byte_strobe();
    test_out_of_range();
    test_w_before_aw();
    test_contention();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d miscompares=%0d", vectors, errors);
    $fatal(1);
  end
endmodule
